// File: rtl/banked_ram_pkg.sv
// Shared constants, types and helpers for the banked on-chip RAM.
package banked_ram_pkg;

    localparam int BANK_DEPTH = 512;
    localparam int BANK_AW    = 9;
    localparam int SEL_IDX_W  = 8;

    typedef struct packed {
        logic                 valid;
        logic                 oor;
        logic [SEL_IDX_W-1:0] idx;
    } bank_sel_t;

    // "No bank": an out-of-range select forces the read mux to zero
    localparam bank_sel_t SEL_NONE = '{valid: 1'b0, oor: 1'b1, idx: '0};

    function automatic int bank_count_to_aw(input int n);
        return $clog2(n * BANK_DEPTH);
    endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// One 512-word bank with byte-masked writes and a read-first registered read port.
module ram_bank
    import banked_ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int BE_W       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [BANK_AW-1:0]    raddr,
    input  logic                  we,
    input  logic [BANK_AW-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_W-1:0]       wbe,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [BANK_DEPTH];

    // Byte-masked write port
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) begin
                    mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read port; output holds while not enabled, old word returned on collision
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/banked_ram.sv
// Parametrised banked RAM: bank decode, registered read select, optional output stage,
// out-of-range reporting and a saturating error counter.
module banked_ram
    import banked_ram_pkg::*;
#(
    parameter  int NUM_BANKS  = 3,
    parameter  int DATA_WIDTH = 8,
    parameter  int OUT_REG    = 0,
    parameter  int ERR_CNT_W  = 8,
    localparam int ADDR_W     = bank_count_to_aw(NUM_BANKS),
    localparam int BE_W       = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_W-1:0]       wbe,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rerr,
    output logic                  werr,
    input  logic                  clr_err,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam logic [ADDR_W:0]    MEM_DEPTH = (ADDR_W + 1)'(NUM_BANKS * BANK_DEPTH);
    localparam logic [ERR_CNT_W:0] ERR_MAX   = {1'b0, {ERR_CNT_W{1'b1}}};

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("banked_ram: DATA_WIDTH must be a multiple of 8");
    end
    if (NUM_BANKS < 1 || NUM_BANKS > (1 << SEL_IDX_W)) begin : g_bad_banks
        $error("banked_ram: NUM_BANKS out of supported range");
    end
    if (ERR_CNT_W < 2) begin : g_bad_cnt
        $error("banked_ram: ERR_CNT_W must be at least 2");
    end

    logic                  rd_oor_s;
    logic                  wr_oor_s;
    logic [SEL_IDX_W-1:0]  rd_idx_s;
    logic [SEL_IDX_W-1:0]  wr_idx_s;
    logic [BANK_AW-1:0]    rd_word_s;
    logic [BANK_AW-1:0]    wr_word_s;
    logic [NUM_BANKS-1:0]  bank_re_s;
    logic [NUM_BANKS-1:0]  bank_we_s;
    logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];
    logic [DATA_WIDTH-1:0] rdata_mux_s;
    logic [1:0]            err_inc_s;
    logic [ERR_CNT_W:0]    err_sum_s;
    logic [ERR_CNT_W-1:0]  err_cnt_nxt_s;
    bank_sel_t             sel_r;
    logic                  werr_r;
    logic [ERR_CNT_W-1:0]  err_cnt_r;

    // Split addresses into bank index and word, flag out-of-range
    always_comb begin
        rd_oor_s  = ({1'b0, raddr} >= MEM_DEPTH);
        wr_oor_s  = ({1'b0, waddr} >= MEM_DEPTH);
        rd_idx_s  = SEL_IDX_W'(raddr >> BANK_AW);
        wr_idx_s  = SEL_IDX_W'(waddr >> BANK_AW);
        rd_word_s = raddr[BANK_AW-1:0];
        wr_word_s = waddr[BANK_AW-1:0];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_re_s[b] = re & ~reset & ~rd_oor_s & (rd_idx_s == SEL_IDX_W'(b));
        assign bank_we_s[b] = we & ~reset & ~wr_oor_s & (wr_idx_s == SEL_IDX_W'(b));

        ram_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank (
            .clk   (clk),
            .re    (bank_re_s[b]),
            .raddr (rd_word_s),
            .we    (bank_we_s[b]),
            .waddr (wr_word_s),
            .wdata (wdata),
            .wbe   (wbe),
            .rdata (bank_rdata_s[b])
        );
    end

    // Read mux driven only by the registered select
    always_comb begin
        rdata_mux_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rdata_mux_s = rdata_mux_s |
                ((!sel_r.oor && sel_r.idx == SEL_IDX_W'(b)) ? bank_rdata_s[b] : '0);
        end
    end

    // Saturating next value of the error counter; two errors in one cycle add 2
    always_comb begin
        err_inc_s = {1'b0, re & rd_oor_s} + {1'b0, we & wr_oor_s};
        err_sum_s = {1'b0, err_cnt_r} + {{(ERR_CNT_W - 1){1'b0}}, err_inc_s};
        if (err_sum_s > ERR_MAX) begin
            err_cnt_nxt_s = {ERR_CNT_W{1'b1}};
        end else begin
            err_cnt_nxt_s = err_sum_s[ERR_CNT_W-1:0];
        end
    end

    // Registered bank select, write-error pulse and error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r     <= SEL_NONE;
            werr_r    <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            sel_r.valid <= re;
            if (re) begin
                sel_r.oor <= rd_oor_s;
                sel_r.idx <= rd_idx_s;
            end
            werr_r <= we & wr_oor_s;
            if (clr_err) begin
                err_cnt_r <= '0;
            end else begin
                err_cnt_r <= err_cnt_nxt_s;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] rdata_q_r;
        logic                  rvalid_q_r;
        logic                  rerr_q_r;

        // Extra output stage for timing; adds one cycle of read latency
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_q_r  <= '0;
                rvalid_q_r <= 1'b0;
                rerr_q_r   <= 1'b0;
            end else begin
                rdata_q_r  <= rdata_mux_s;
                rvalid_q_r <= sel_r.valid;
                rerr_q_r   <= sel_r.valid & sel_r.oor;
            end
        end

        assign rdata  = rdata_q_r;
        assign rvalid = rvalid_q_r;
        assign rerr   = rerr_q_r;
    end else begin : g_no_out_reg
        assign rdata  = rdata_mux_s;
        assign rvalid = sel_r.valid;
        assign rerr   = sel_r.valid & sel_r.oor;
    end

    assign werr    = werr_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised on-chip data/instruction memory built from NUM_BANKS banks of 512 words each.
- Successor to the fixed 3x512x8 banked wrapper. Adds generic width and depth, byte-write enables, and a read-data path that uses a registered bank select.
- Adds an optional output register stage, read-valid signalling, out-of-range error reporting and a saturating error counter.
- Sits between the CPU load/store and fetch logic and the ICE40 block RAMs. Bank bodies are written so the tools infer SB_RAM512x8-class primitives.

Parameters:
- NUM_BANKS, 3, number of 512-word banks; total depth is NUM_BANKS*512.
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- OUT_REG, 0, 0 gives a read latency of 1 cycle; 1 adds an output register, giving a read latency of 2 cycles.
- ERR_CNT_W, 8, width of the saturating error counter.
- ADDR_W (derived), $clog2(NUM_BANKS*512), address width; 11 at the defaults.

Ports:
- clk  in  1  single clock; reads and writes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- re  in  1  read request, sampled at the rising edge.
- raddr  in  ADDR_W  read word address.
- we  in  1  write request.
- waddr  in  ADDR_W  write word address.
- wdata  in  DATA_WIDTH  write data.
- wbe  in  DATA_WIDTH/8  byte write enables; bit i covers wdata[8i+7:8i].
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata is valid this cycle (one pulse per accepted read).
- rerr  out  1  qualifies rvalid; the read address was out of range.
- werr  out  1  one-cycle pulse, the cycle after an out-of-range write.
- clr_err  in  1  synchronous clear of err_cnt.
- err_cnt  out  ERR_CNT_W  saturating count of out-of-range accesses.

Behaviour:
- Reset values: rdata=0, rvalid=0, rerr=0, werr=0, err_cnt=0, and the registered bank select is set to "none". Memory contents are not cleared.
- Address split:
  - bank index = addr[ADDR_W-1:9], word within bank = addr[8:0].
  - An address is out of range when addr >= NUM_BANKS*512; at the defaults that is addresses 1536..2047.
- Read:
  - When re=1 at edge N, only the addressed bank is enabled. The bank index and range flag are registered.
  - OUT_REG=0: at cycle N+1, rdata = registered-bank output, rvalid=1, rerr=0.
  - OUT_REG=1: the same result appears one cycle later, at N+2.
  - Out-of-range read: no bank is enabled; rdata=0, rvalid=1, rerr=1 at the same latency as a normal read.
  - re=0: rvalid=0 next cycle. rdata holds its last value because bank outputs hold when not enabled.
  - Output muxing uses the registered select only, never the live raddr.
- Write:
  - When we=1 and the address is in range, the bytes with wbe[i]=1 are written at the edge. All other bytes are untouched.
  - wbe=0 with we=1 writes nothing and is not an error.
  - Out-of-range write: nothing is written; werr=1 in the following cycle.
- Simultaneous read and write to the same address: read-first, i.e. rdata returns the old word. The new word is visible to the next read.
- Simultaneous read and write to different banks, or to the same bank at different words: both complete independently.
- err_cnt:
  - Increments by 1 for each out-of-range read and by 1 for each out-of-range write. Both in one cycle add 2.
  - Saturates at 2^ERR_CNT_W-1.
  - clr_err=1 sets it to 0 and takes priority over a same-cycle increment.
- Reset mid-operation:
  - reset asserted drops rvalid/rerr/werr immediately, and in-flight reads are discarded.
  - Writes are gated with !reset, so no write occurs while reset is high.
  - After reset release, the first read returns the pre-reset memory contents.
- Parameter checks at elaboration: DATA_WIDTH%8 != 0 is an error; NUM_BANKS < 1 is an error.

Decomposition:
- Package banked_ram_pkg holds:
  - BANK_DEPTH=512 and BANK_AW=9 constants;
  - the function bank_count_to_aw(n) returning $clog2(n*512);
  - typedef bank_sel_t, a struct {logic valid; logic oor; idx} used for the registered select.
- Sub-module ram_bank: one 512 x DATA_WIDTH bank with read enable, write enable and byte enables, and read-first behaviour. It is instantiated NUM_BANKS times in a generate loop.

Test Plan (NUM_BANKS=3 unless stated):
- Basic write/read, DATA_WIDTH=8, OUT_REG=0: write 0xA5@0x000, 0x3C@0x200 and 0x7E@0x5FF; read each address -> rdata 0xA5, 0x3C, 0x7E respectively, each one cycle after re, with rvalid=1 and rerr=0.
- Byte enables, DATA_WIDTH=32: write 0x11223344@0x010 with wbe=1111, then 0xAABBCCDD with wbe=0101 -> read returns 0x11BB33DD.
- Out of range: read 0x600 -> rvalid=1, rerr=1, rdata=0. Write 0x7FF -> werr pulse; a subsequent read of 0x1FF is unchanged; err_cnt=2. Then 300 OOR reads with ERR_CNT_W=8 -> err_cnt=255. clr_err -> err_cnt=0.
- Read-first collision: mem[0x100]=0x01; in the same cycle write 0x02@0x100 and read 0x100 -> rdata 0x01; the next read returns 0x02.
- OUT_REG=1 back-to-back reads at 0x000, 0x200 and 0x400 on consecutive cycles -> rvalid high for 3 cycles starting 2 cycles after the first re. The data arrives in order with no cross-bank mixing, even though raddr changes every cycle.
- Reset mid-read: issue re, then assert reset in the next cycle -> rvalid stays 0 and err_cnt=0. After release, a read of a previously written address returns the retained data.
